// File: rtl/imem_access_arbiter.sv
// Shares the read-only instruction memory between fetch and debug readers.
// Define IMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration on contention.
module imem_access_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 2
) (
   input  logic              CLK,
   input  logic              resetl,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_rvalid,
   output logic [DATA_W-1:0] fetch_rdata,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              misalign,
   output logic              busy
);

   typedef enum logic {IDLE, WAIT} state_t;
   typedef enum logic {FETCH, DBG} owner_t;

   localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

   state_t            state, state_n;
   owner_t            owner, owner_n;
   logic [3:0]        cnt, cnt_n;
   logic              mis_q, mis_n;
   logic [ADDR_W-1:0] maddr_n;
   logic              fgnt_n, dgnt_n;
   logic              frv_n, drv_n, misal_n;
   logic [DATA_W-1:0] frd_n, drd_n;
   logic              win_dbg;
   logic [ADDR_W-1:0] win_addr;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
   owner_t            last_owner, last_n;

   // On contention the port that did not win last time goes first.
   always_comb begin
      win_dbg = dbg_req && (!fetch_req || (last_owner == FETCH));
   end
`else
   always_comb begin
      win_dbg = dbg_req && !fetch_req;
   end
`endif

   assign win_addr = win_dbg ? dbg_addr : fetch_addr;
   assign busy     = (state == WAIT);

   always_comb begin
      state_n = state;
      owner_n = owner;
      cnt_n   = cnt;
      mis_n   = mis_q;
      maddr_n = mem_addr;
      fgnt_n  = 1'b0;
      dgnt_n  = 1'b0;
      frv_n   = 1'b0;
      drv_n   = 1'b0;
      misal_n = 1'b0;
      frd_n   = fetch_rdata;
      drd_n   = dbg_rdata;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      last_n  = last_owner;
`endif
      unique case (state)
         IDLE: begin
            if (fetch_req || dbg_req) begin
               state_n = WAIT;
               cnt_n   = CNT_INIT;
               owner_n = win_dbg ? DBG : FETCH;
               mis_n   = |win_addr[1:0];
               maddr_n = {win_addr[ADDR_W-1:2], 2'b00};
               fgnt_n  = !win_dbg;
               dgnt_n  = win_dbg;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
               last_n  = win_dbg ? DBG : FETCH;
`endif
            end
         end
         WAIT: begin
            if (cnt != 4'd0) begin
               cnt_n = cnt - 4'd1;
            end else begin
               state_n = IDLE;
               misal_n = mis_q;
               if (owner == DBG) begin
                  drv_n = 1'b1;
                  drd_n = mem_data;
               end else begin
                  frv_n = 1'b1;
                  frd_n = mem_data;
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state        <= IDLE;
         owner        <= FETCH;
         cnt          <= 4'd0;
         mis_q        <= 1'b0;
         mem_addr     <= '0;
         fetch_gnt    <= 1'b0;
         dbg_gnt      <= 1'b0;
         fetch_rvalid <= 1'b0;
         dbg_rvalid   <= 1'b0;
         misalign     <= 1'b0;
         fetch_rdata  <= '0;
         dbg_rdata    <= '0;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
         last_owner   <= DBG;
`endif
      end else begin
         state        <= state_n;
         owner        <= owner_n;
         cnt          <= cnt_n;
         mis_q        <= mis_n;
         mem_addr     <= maddr_n;
         fetch_gnt    <= fgnt_n;
         dbg_gnt      <= dgnt_n;
         fetch_rvalid <= frv_n;
         dbg_rvalid   <= drv_n;
         misalign     <= misal_n;
         fetch_rdata  <= frd_n;
         dbg_rdata    <= drd_n;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
         last_owner   <= last_n;
`endif
      end
   end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Bench for imem_access_arbiter: directed steps plus random traffic
// checked against a transaction-level timing model.
module tb_imem_access_arbiter;

   localparam int RD_LAT = 2;

   logic        CLK;
   logic        resetl;
   logic        fetch_req, dbg_req;
   logic [63:0] fetch_addr, dbg_addr;
   logic        fetch_gnt, dbg_gnt;
   logic        fetch_rvalid, dbg_rvalid;
   logic [31:0] fetch_rdata, dbg_rdata;
   logic [63:0] mem_addr;
   logic [31:0] mem_data;
   logic        misalign, busy;

   imem_access_arbiter #(.ADDR_W(64), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
      .CLK(CLK), .resetl(resetl),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
      .fetch_rdata(fetch_rdata),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
      .dbg_rdata(dbg_rdata),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .misalign(misalign), .busy(busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory returns garbage until its address has been stable long enough.
   logic [31:0] mem [0:63];
   logic [63:0] last_a = '0;
   int          age = 0;

   always @(negedge CLK) begin
      if (mem_addr !== last_a) begin
         last_a <= mem_addr;
         age    <= 0;
      end else if (age < 100) begin
         age <= age + 1;
      end
   end

   assign mem_data = (age >= RD_LAT - 1) ? mem[mem_addr[7:2]] : 32'hBAD0BAD0;

   int          cmp = 0;
   int          mism = 0;
   int          cyc = 0;
   bit          acc_v;
   int          acc_e;
   bit          acc_dbg;
   logic [63:0] acc_a;
   logic [63:0] e_maddr;
   logic [31:0] ef_rd, ed_rd;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
   bit          last_dbg;
`endif

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      cmp++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      acc_v   = 1'b0;
      acc_e   = 0;
      acc_dbg = 1'b0;
      acc_a   = '0;
      e_maddr = '0;
      ef_rd   = '0;
      ed_rd   = '0;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      last_dbg = 1'b1;
`endif
   endtask

   task automatic check_all();
      bit rv;
      rv = acc_v && (cyc == acc_e + RD_LAT);
      chk("fetch_gnt", fetch_gnt, acc_v && cyc == acc_e && !acc_dbg);
      chk("dbg_gnt", dbg_gnt, acc_v && cyc == acc_e && acc_dbg);
      chk("fetch_rvalid", fetch_rvalid, rv && !acc_dbg);
      chk("dbg_rvalid", dbg_rvalid, rv && acc_dbg);
      chk("misalign", misalign, rv && (acc_a[1:0] != 2'b00));
      chk("busy", busy,
          acc_v && cyc >= acc_e && cyc < acc_e + RD_LAT);
      chk("mem_addr", mem_addr, e_maddr);
      chk("fetch_rdata", fetch_rdata, ef_rd);
      chk("dbg_rdata", dbg_rdata, ed_rd);
   endtask

   task automatic tick();
      bit          wd;
      logic [63:0] wa;
      @(posedge CLK);
      cyc++;
      if (resetl) begin
         if (acc_v && cyc == acc_e + RD_LAT) begin
            if (acc_dbg) ed_rd = mem[acc_a[7:2]];
            else         ef_rd = mem[acc_a[7:2]];
         end
         if ((!acc_v || cyc > acc_e + RD_LAT) && (fetch_req || dbg_req)) begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
            wd = dbg_req && (!fetch_req || !last_dbg);
            last_dbg = wd;
`else
            wd = dbg_req && !fetch_req;
`endif
            wa      = wd ? dbg_addr : fetch_addr;
            acc_v   = 1'b1;
            acc_e   = cyc;
            acc_dbg = wd;
            acc_a   = wa;
            e_maddr = {wa[63:2], 2'b00};
         end
      end
      #1;
      check_all();
   endtask

   task automatic run_req(input bit d, input logic [63:0] a,
                          input logic [31:0] exp_rd);
      int n;
      if (d) begin dbg_req = 1'b1; dbg_addr = a; end
      else   begin fetch_req = 1'b1; fetch_addr = a; end
      n = 0;
      do begin tick(); n++; end
      while (!(d ? dbg_gnt : fetch_gnt) && n < 20);
      chk("gnt_seen", d ? dbg_gnt : fetch_gnt, 1'b1);
      if (d) dbg_req = 1'b0; else fetch_req = 1'b0;
      n = 0;
      do begin tick(); n++; end
      while (!(d ? dbg_rvalid : fetch_rvalid) && n < 20);
      chk("rvalid_seen", d ? dbg_rvalid : fetch_rvalid, 1'b1);
      chk("rdata_value", d ? dbg_rdata : fetch_rdata, exp_rd);
   endtask

   initial begin
      int n;
      bit exp_d;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0]  = 32'hF84003E9;
      mem[5]  = 32'hAA0B014A;
      mem[6]  = 32'h8A0A018C;
      mem[10] = 32'h17FFFFFD;
      resetl = 1'b0;
      fetch_req = 1'b0; fetch_addr = '0;
      dbg_req = 1'b0;   dbg_addr = '0;
      model_reset();
      #2;
      check_all();
      tick();
      tick();
      resetl = 1'b1;

      // single fetch from 0x0
      fetch_req = 1'b1; fetch_addr = 64'h0;
      tick();
      chk("t1_gnt", fetch_gnt, 1'b1);
      chk("t1_maddr", mem_addr, 64'h0);
      chk("t1_busy", busy, 1'b1);
      fetch_req = 1'b0;
      tick();
      chk("t1_rv_early", fetch_rvalid, 1'b0);
      tick();
      chk("t1_rvalid", fetch_rvalid, 1'b1);
      chk("t1_rdata", fetch_rdata, 32'hF84003E9);
      tick();

      // debug read, fetch data untouched
      run_req(1'b1, 64'h28, 32'h17FFFFFD);
      chk("t2_frd_hold", fetch_rdata, 32'hF84003E9);
      tick();

      // simultaneous requests
      fetch_req = 1'b1; fetch_addr = 64'h14;
      dbg_req = 1'b1;   dbg_addr = 64'h18;
      tick();
      chk("t3_fetch_first", fetch_gnt, 1'b1);
      chk("t3_dbg_wait", dbg_gnt, 1'b0);
      fetch_req = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!dbg_gnt && n < 20);
      chk("t3_dbg_gnt", dbg_gnt, 1'b1);
      chk("t3_frd", fetch_rdata, 32'hAA0B014A);
      dbg_req = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!dbg_rvalid && n < 20);
      chk("t3_drd", dbg_rdata, 32'h8A0A018C);
      tick();

      // both held for four accesses
      fetch_req = 1'b1; fetch_addr = 64'h0;
      dbg_req = 1'b1;   dbg_addr = 64'h28;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin tick(); n++; end while (!(fetch_gnt || dbg_gnt) && n < 20);
         chk("t4_gnt_seen", fetch_gnt || dbg_gnt, 1'b1);
`ifdef IMEM_ARB_ROUND_ROBIN_EN
         exp_d = (k % 2) == 1;
`else
         exp_d = 1'b0;
`endif
         chk("t4_order", dbg_gnt, exp_d);
      end
      fetch_req = 1'b0; dbg_req = 1'b0;
      for (int k = 0; k < 4; k++) tick();

      // misaligned fetch
      fetch_req = 1'b1; fetch_addr = 64'h16;
      tick();
      chk("t5_maddr", mem_addr, 64'h14);
      fetch_req = 1'b0;
      tick();
      tick();
      chk("t5_rvalid", fetch_rvalid, 1'b1);
      chk("t5_misalign", misalign, 1'b1);
      chk("t5_rdata", fetch_rdata, 32'hAA0B014A);
      tick();

      // async reset in the middle of an access
      fetch_req = 1'b1; fetch_addr = 64'h28;
      tick();
      chk("t6_gnt", fetch_gnt, 1'b1);
      fetch_req = 1'b0;
      resetl = 1'b0;
      #1;
      model_reset();
      check_all();
      tick();
      tick();
      resetl = 1'b1;
      tick();
      chk("t6_no_rvalid", fetch_rvalid, 1'b0);
      run_req(1'b0, 64'h18, 32'h8A0A018C);
      tick();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         if (fetch_gnt) fetch_req = 1'b0;
         else if (!fetch_req) begin
            if ($urandom_range(0, 2) == 0) begin
               fetch_req = 1'b1; fetch_addr = {$urandom, $urandom};
            end
         end else if ($urandom_range(0, 3) == 0) begin
            fetch_addr = {$urandom, $urandom};
         end
         if (dbg_gnt) dbg_req = 1'b0;
         else if (!dbg_req) begin
            if ($urandom_range(0, 2) == 0) begin
               dbg_req = 1'b1; dbg_addr = {$urandom, $urandom};
            end
         end else if ($urandom_range(0, 3) == 0) begin
            dbg_addr = {$urandom, $urandom};
         end
         tick();
      end
      fetch_req = 1'b0; dbg_req = 1'b0;
      for (int k = 0; k < 6; k++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
      $finish;
   end

endmodule
